// File: rtl/csoc_cmd_pkg.sv
// rtl/csoc_cmd_pkg.sv - shared types and constants for the CSoC command receiver
// Command characters, FSM state encoding and the ASCII hex digit decoder.
package csoc_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_HEX_HI     = 4'd1,
    ST_HEX_LO     = 4'd2,
    ST_RST_HOLD   = 4'd3,
    ST_SCAN_SETUP = 4'd4,
    ST_SCAN_HIGH  = 4'd5,
    ST_RUN_LOW    = 4'd6,
    ST_RUN_HIGH   = 4'd7,
    ST_ACK        = 4'd8
  } state_t;

  localparam logic [7:0] CMD_RST     = 8'h52;  // 'R'
  localparam logic [7:0] CMD_TM_ON   = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_TM_OFF  = 8'h6D;  // 'm'
  localparam logic [7:0] CMD_SCAN_LO = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_SCAN_HI = 8'h48;  // 'H'
  localparam logic [7:0] CMD_RUN     = 8'h50;  // 'P'
  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;

  localparam logic [7:0] DEF_ACK_CHAR = 8'h2E;
  localparam logic [7:0] DEF_NAK_CHAR = 8'h3F;

  // Returns {valid, nibble}; letters rely on the low ASCII nibble of A-F/a-f being 1..6.
  function automatic logic [4:0] hex_to_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      return {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      return {1'b1, c[3:0] + 4'd9};
    end else begin
      return 5'b0_0000;
    end
  endfunction

endpackage

// File: rtl/csoc_pulse_gen.sv
// rtl/csoc_pulse_gen.sv - burst generator for csoc_clk
// Emits count_i pulses, each CLK_HALF cycles low then CLK_HALF cycles high.
module csoc_pulse_gen
  import csoc_cmd_pkg::*;
#(
  parameter int CLK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] count_i,
  output logic       csoc_clk_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       done_o
);

  localparam int HW = $clog2(CLK_HALF + 1);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_HALF - 1);

  logic          active_q, active_d;
  logic          clk_q, clk_d;
  logic [HW-1:0] half_q, half_d;
  logic [7:0]    pulses_q, pulses_d;
  logic          half_end;

  assign half_end   = active_q && (half_q == '0);
  assign rise_o     = half_end && !clk_q;
  // A count of 0 or 1 is the final pulse, so the down-counter never wraps.
  assign done_o     = half_end && clk_q && (pulses_q <= 8'd1);
  assign fall_o     = half_end && clk_q && (pulses_q > 8'd1);
  assign csoc_clk_o = clk_q;

  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    half_d   = half_q;
    pulses_d = pulses_q;
    if (start_i && !active_q) begin
      active_d = 1'b1;
      clk_d    = 1'b0;
      half_d   = HALF_RELOAD;
      pulses_d = count_i;
    end else if (active_q) begin
      if (half_q != '0) begin
        half_d = half_q - 1'b1;
      end else if (!clk_q) begin
        clk_d  = 1'b1;
        half_d = HALF_RELOAD;
      end else if (pulses_q <= 8'd1) begin
        clk_d    = 1'b0;
        active_d = 1'b0;
        pulses_d = 8'd0;
      end else begin
        clk_d    = 1'b0;
        half_d   = HALF_RELOAD;
        pulses_d = pulses_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      clk_q    <= 1'b0;
      half_q   <= '0;
      pulses_q <= 8'd0;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      half_q   <= half_d;
      pulses_q <= pulses_d;
    end
  end

endmodule

// File: rtl/csoc_cmd_rx.sv
// rtl/csoc_cmd_rx.sv - UART command decoder driving CSoC reset, test mode, scan and clocks
// Single-character commands; every completed command answers with one ack/nak byte.
module csoc_cmd_rx
  import csoc_cmd_pkg::*;
#(
  parameter int         CLK_HALF   = 4,
  parameter int         RST_CYCLES = 16,
  parameter logic [7:0] ACK_CHAR   = DEF_ACK_CHAR,
  parameter logic [7:0] NAK_CHAR   = DEF_NAK_CHAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_tm,
  output logic       csoc_test_se,
  output logic       csoc_scan_in,
  output logic       busy,
  output logic       err_overrun
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [RCW-1:0] RST_RELOAD = RCW'(RST_CYCLES - 1);

  state_t         state_q, state_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           rstn_q, rstn_d;
  logic           tm_q, tm_d;
  logic           se_q, se_d;
  logic           scan_q, scan_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [3:0]     nib_q, nib_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  logic           pg_start;
  logic [7:0]     pg_count;
  logic           pg_rise, pg_fall, pg_done;
  logic [4:0]     hex_w;
  logic           accepting;

  assign hex_w     = hex_to_nib(rx_data);
  assign accepting = (state_q == ST_IDLE) || (state_q == ST_HEX_HI) || (state_q == ST_HEX_LO);

  csoc_pulse_gen #(
    .CLK_HALF(CLK_HALF)
  ) u_pulse_gen (
    .clk       (clk),
    .rst       (rst),
    .start_i   (pg_start),
    .count_i   (pg_count),
    .csoc_clk_o(csoc_clk),
    .rise_o    (pg_rise),
    .fall_o    (pg_fall),
    .done_o    (pg_done)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    rstn_d     = 1'b1;
    tm_d       = tm_q;
    se_d       = se_q;
    scan_d     = scan_q;
    err_d      = err_q;
    nib_d      = nib_q;
    rcnt_d     = rcnt_q;
    pg_start   = 1'b0;
    pg_count   = 8'd1;

    if (new_rx_data && !accepting) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (new_rx_data) begin
          case (rx_data)
            CMD_RST: begin
              state_d = ST_RST_HOLD;
              rstn_d  = 1'b0;
              rcnt_d  = RST_RELOAD;
            end
            CMD_TM_ON, CMD_TM_OFF: begin
              tm_d       = (rx_data == CMD_TM_ON);
              state_d    = ST_ACK;
              tx_start_d = 1'b1;
              tx_data_d  = ACK_CHAR;
            end
            CMD_SCAN_LO, CMD_SCAN_HI: begin
              scan_d   = (rx_data == CMD_SCAN_HI);
              se_d     = 1'b1;
              pg_start = 1'b1;
              state_d  = ST_SCAN_SETUP;
            end
            CMD_RUN: state_d = ST_HEX_HI;
            CHAR_CR, CHAR_LF: state_d = ST_IDLE;
            default: begin
              state_d    = ST_ACK;
              tx_start_d = 1'b1;
              tx_data_d  = NAK_CHAR;
            end
          endcase
        end
      end
      ST_HEX_HI: begin
        if (new_rx_data) begin
          if (hex_w[4]) begin
            nib_d   = hex_w[3:0];
            state_d = ST_HEX_LO;
          end else begin
            state_d    = ST_ACK;
            tx_start_d = 1'b1;
            tx_data_d  = NAK_CHAR;
          end
        end
      end
      ST_HEX_LO: begin
        if (new_rx_data) begin
          state_d    = ST_ACK;
          tx_start_d = 1'b1;
          tx_data_d  = hex_w[4] ? ACK_CHAR : NAK_CHAR;
          if (hex_w[4] && ({nib_q, hex_w[3:0]} != 8'd0)) begin
            state_d    = ST_RUN_LOW;
            tx_start_d = 1'b0;
            tx_data_d  = tx_data_q;
            se_d       = 1'b0;
            pg_start   = 1'b1;
            pg_count   = {nib_q, hex_w[3:0]};
          end
        end
      end
      ST_RST_HOLD: begin
        if (rcnt_q == '0) begin
          state_d    = ST_ACK;
          tx_start_d = 1'b1;
          tx_data_d  = ACK_CHAR;
        end else begin
          rstn_d = 1'b0;
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      ST_SCAN_SETUP: begin
        if (pg_rise) state_d = ST_SCAN_HIGH;
      end
      ST_SCAN_HIGH: begin
        if (pg_done) begin
          state_d    = ST_ACK;
          tx_start_d = 1'b1;
          tx_data_d  = ACK_CHAR;
        end
      end
      ST_RUN_LOW: begin
        if (pg_rise) state_d = ST_RUN_HIGH;
      end
      ST_RUN_HIGH: begin
        if (pg_done) begin
          se_d       = 1'b1;
          state_d    = ST_ACK;
          tx_start_d = 1'b1;
          tx_data_d  = ACK_CHAR;
        end else if (pg_fall) begin
          state_d = ST_RUN_LOW;
        end
      end
      ST_ACK: begin
        if (tx_ready_i) begin
          tx_start_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rstn_q     <= 1'b0;
      tm_q       <= 1'b1;
      se_q       <= 1'b1;
      scan_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      nib_q      <= 4'd0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rstn_q     <= rstn_d;
      tm_q       <= tm_d;
      se_q       <= se_d;
      scan_q     <= scan_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      nib_q      <= nib_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign tx_start_o   = tx_start_q;
  assign tx_data_o    = tx_data_q;
  assign csoc_rstn    = rstn_q;
  assign csoc_test_tm = tm_q;
  assign csoc_test_se = se_q;
  assign csoc_scan_in = scan_q;
  assign busy         = busy_q;
  assign err_overrun  = err_q;

endmodule

// File: tb/tb_csoc_cmd_rx.sv
// tb/tb_csoc_cmd_rx.sv - scoreboard bench for csoc_cmd_rx
module tb_csoc_cmd_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic       tx_ready_i = 1'b0;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       csoc_clk, csoc_rstn, csoc_test_tm, csoc_test_se, csoc_scan_in;
  logic       busy, err_overrun;

  always #5 clk = ~clk;

  csoc_cmd_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .csoc_clk    (csoc_clk),
    .csoc_rstn   (csoc_rstn),
    .csoc_test_tm(csoc_test_tm),
    .csoc_test_se(csoc_test_se),
    .csoc_scan_in(csoc_scan_in),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  typedef struct {
    logic [7:0] data;
    int         pulses;
    int         rlow;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   acks_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input logic [7:0] data, input int pulses, input int rlow);
    exp_t e;
    e.data = data;
    e.pulses = pulses;
    e.rlow = rlow;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1 new_rx_data = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // Monitor: counts csoc_clk rises and reset-hold cycles between acks, scores each ack.
  initial begin
    int   pulses_seen;
    int   rlow_seen;
    logic prev_clk;
    logic prev_start;
    exp_t e;
    pulses_seen = 0;
    rlow_seen = 0;
    prev_clk = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses_seen = 0;
        rlow_seen = 0;
        prev_clk = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (csoc_clk && !prev_clk) pulses_seen++;
        if (!csoc_rstn && busy) rlow_seen++;
        if (tx_start_o && !prev_start) begin
          acks_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got %02h expected none", tx_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("ack_data", 32'(tx_data_o), 32'(e.data));
            chk("ack_pulses", 32'(pulses_seen), 32'(e.pulses));
            chk("ack_rst_low", 32'(rlow_seen), 32'(e.rlow));
          end
          pulses_seen = 0;
          rlow_seen = 0;
        end
        prev_clk = csoc_clk;
        prev_start = tx_start_o;
      end
    end
  end

  // Transmitter model: accepts each requested byte a couple of cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start_o && !rst) begin
        repeat (2) @(posedge clk);
        #1 tx_ready_i = 1'b1;
        @(posedge clk);
        #1 tx_ready_i = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cnt;
    int   acks_before;
    logic seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx_start", 32'(tx_start_o), 32'd0);
    chk("rst_tx_data", 32'(tx_data_o), 32'h00);
    chk("rst_csoc_clk", 32'(csoc_clk), 32'd0);
    chk("rst_rstn", 32'(csoc_rstn), 32'd0);
    chk("rst_tm", 32'(csoc_test_tm), 32'd1);
    chk("rst_se", 32'(csoc_test_se), 32'd1);
    chk("rst_scan_in", 32'(csoc_scan_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_overrun), 32'd0);
    @(posedge clk);
    #1 chk("rstn_release", 32'(csoc_rstn), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // 'H': scan bit 1, low 4 cycles then high 4 cycles
    expect_ack(8'h2E, 1, 0);
    send_byte(8'h48);
    chk("h_scan_in", 32'(csoc_scan_in), 32'd1);
    chk("h_se", 32'(csoc_test_se), 32'd1);
    chk("h_busy", 32'(busy), 32'd1);
    chk("h_clk_k0", 32'(csoc_clk), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1 chk($sformatf("h_clk_k%0d", k), 32'(csoc_clk), (k >= 4 && k < 8) ? 32'd1 : 32'd0);
    end
    chk("h_tx_start", 32'(tx_start_o), 32'd1);
    wait_idle("h_idle", 50);

    expect_ack(8'h2E, 1, 0);
    send_byte(8'h4C);
    chk("l_scan_in", 32'(csoc_scan_in), 32'd0);
    wait_idle("l_idle", 50);

    // 'P03': se low for exactly 3 periods of 8 cycles
    expect_ack(8'h2E, 3, 0);
    send_byte(8'h50);
    send_byte(8'h30);
    send_byte(8'h33);
    cnt = 0;
    while (csoc_test_se == 1'b0 && cnt < 5000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("p03_se_low_cycles", 32'(cnt), 32'd24);
    chk("p03_se_back", 32'(csoc_test_se), 32'd1);
    wait_idle("p03_idle", 50);

    expect_ack(8'h2E, 0, 0);
    send_byte(8'h50);
    send_byte(8'h30);
    send_byte(8'h30);
    wait_idle("p00_idle", 50);

    expect_ack(8'h3F, 0, 0);
    send_byte(8'h50);
    send_byte(8'h67);
    wait_idle("pg_idle", 50);

    expect_ack(8'h3F, 0, 0);
    send_byte(8'h78);
    wait_idle("x_idle", 50);

    // LF is silently ignored
    acks_before = acks_seen;
    send_byte(8'h0A);
    chk("lf_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 if (tx_start_o) seen = 1'b1;
    end
    chk("lf_no_tx", 32'(seen), 32'd0);
    chk("lf_no_ack", 32'(acks_seen), 32'(acks_before));

    expect_ack(8'h2E, 0, 16);
    send_byte(8'h52);
    chk("r_rstn_low", 32'(csoc_rstn), 32'd0);
    wait_idle("r_idle", 100);
    chk("r_rstn_high", 32'(csoc_rstn), 32'd1);

    expect_ack(8'h2E, 0, 0);
    send_byte(8'h6D);
    chk("m_tm_off", 32'(csoc_test_tm), 32'd0);
    wait_idle("m_idle", 50);
    expect_ack(8'h2E, 0, 0);
    send_byte(8'h4D);
    chk("M_tm_on", 32'(csoc_test_tm), 32'd1);
    wait_idle("M_idle", 50);

    // 'PFF' with a byte injected mid-burst
    expect_ack(8'h2E, 255, 0);
    send_byte(8'h50);
    send_byte(8'h46);
    send_byte(8'h46);
    repeat (50) @(posedge clk);
    #1 chk("ff_err_before", 32'(err_overrun), 32'd0);
    send_byte(8'h5A);
    chk("ff_err_set", 32'(err_overrun), 32'd1);
    wait_idle("ff_idle", 3000);
    chk("ff_err_sticky", 32'(err_overrun), 32'd1);

    // reset in the middle of a burst
    send_byte(8'h50);
    send_byte(8'h38);
    send_byte(8'h30);
    chk("p80_se_low", 32'(csoc_test_se), 32'd0);
    repeat (101) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("abort_clk", 32'(csoc_clk), 32'd0);
    chk("abort_se", 32'(csoc_test_se), 32'd1);
    chk("abort_tm", 32'(csoc_test_tm), 32'd1);
    chk("abort_err", 32'(err_overrun), 32'd0);
    chk("abort_tx_start", 32'(tx_start_o), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1 if (tx_start_o || csoc_clk) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

    expect_ack(8'h2E, 1, 0);
    send_byte(8'h48);
    wait_idle("post_abort_idle", 50);

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ack_total", 32'(acks_seen), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
